// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester handshake, ALU drive and response signals.
// Ports: none (clock and reset stay plain ports on the arbiter).
// Modports: slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  // requester 0 (execute stage)
  logic            i_req0_valid;
  logic            o_req0_ready;
  logic [XLEN-1:0] i_req0_op_a;
  logic [XLEN-1:0] i_req0_op_b;
  logic [OPW-1:0]  i_req0_alu_op;
  // requester 1 (address/branch helper)
  logic            i_req1_valid;
  logic            o_req1_ready;
  logic [XLEN-1:0] i_req1_op_a;
  logic [XLEN-1:0] i_req1_op_b;
  logic [OPW-1:0]  i_req1_alu_op;
  // ALU drive and result
  logic [XLEN-1:0] o_alu_op_a;
  logic [XLEN-1:0] o_alu_op_b;
  logic [OPW-1:0]  o_alu_op;
  logic [XLEN-1:0] i_alu_data;
  // response
  logic            o_rsp_valid;
  logic            o_rsp_id;
  logic [XLEN-1:0] o_rsp_data;
  logic            o_rsp_err;
  logic            i_rsp_ready;

  modport slave (
    input  i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_alu_op,
    input  i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_alu_op,
    input  i_alu_data, i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_alu_op_a, o_alu_op_b, o_alu_op,
    output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );

  modport master (
    output i_req0_valid, i_req0_op_a, i_req0_op_b, i_req0_alu_op,
    output i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_alu_op,
    output i_alu_data, i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_op_a, o_alu_op_b, o_alu_op,
    input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Latency: grant at edge N, response valid after edge N+1; at least 3 cycles per transaction.
// Ports: i_clk, i_rst_n (async active-low), bus (alu_arbiter_if.slave); readies only in IDLE,
// response held until i_rsp_ready.
module alu_arbiter #(
  parameter int XLEN    = 32,
  parameter int OPW     = 4,
  parameter int NUM_OPS = 10
) (
  input logic           i_clk,
  input logic           i_rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // One extra bit so a NUM_OPS equal to 2**OPW still compares correctly.
  localparam logic [OPW:0] NUM_OPS_W = NUM_OPS[OPW:0];

  state_t state, state_nxt;
  logic   last_grant;
  logic   cur_id;
  logic   ready0, ready1;
  logic   grant;
  logic   op_illegal;

  // Next state and combinational readies. A port wins contention when the
  // other port held the most recent grant.
  always_comb begin
    state_nxt = state;
    ready0    = 1'b0;
    ready1    = 1'b0;
    case (state)
      IDLE: begin
        ready0 = bus.i_req0_valid && (!bus.i_req1_valid || last_grant);
        ready1 = bus.i_req1_valid && (!bus.i_req0_valid || !last_grant);
        if (ready0 || ready1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant            = ready0 || ready1;
  assign bus.o_req0_ready = ready0;
  assign bus.o_req1_ready = ready1;
  assign op_illegal       = ({1'b0, bus.o_alu_op} >= NUM_OPS_W);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant      <= 1'b1;
      cur_id          <= 1'b0;
      bus.o_alu_op_a  <= '0;
      bus.o_alu_op_b  <= '0;
      bus.o_alu_op    <= '0;
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_id    <= 1'b0;
      bus.o_rsp_data  <= '0;
      bus.o_rsp_err   <= 1'b0;
    end else begin
      // The ALU operand registers move only on a grant edge.
      if (grant) begin
        cur_id     <= ready1;
        last_grant <= ready1;
        if (ready1) begin
          bus.o_alu_op_a <= bus.i_req1_op_a;
          bus.o_alu_op_b <= bus.i_req1_op_b;
          bus.o_alu_op   <= bus.i_req1_alu_op;
        end else begin
          bus.o_alu_op_a <= bus.i_req0_op_a;
          bus.o_alu_op_b <= bus.i_req0_op_b;
          bus.o_alu_op   <= bus.i_req0_alu_op;
        end
      end

      // Capture the ALU result; an illegal opcode reports zero data.
      if (state == EXEC) begin
        bus.o_rsp_valid <= 1'b1;
        bus.o_rsp_id    <= cur_id;
        bus.o_rsp_err   <= op_illegal;
        bus.o_rsp_data  <= op_illegal ? '0 : bus.i_alu_data;
      end

      if (state == RESP && bus.i_rsp_ready) begin
        bus.o_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU stand-in.
// Transaction-level reference: expected winner from last-grant history, expected data from the opcode table.
// Directed cases (single, contention, backpressure, illegal op, reset, withdrawal) then random transactions.
module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit   m_last;   // reference: port that received the most recent grant

  alu_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

  alu_arbiter #(.XLEN(XLEN), .OPW(OPW), .NUM_OPS(10)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour; illegal codes return a poison value the arbiter must mask.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a | b;
      4'd6:    return a & b;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb bus.i_alu_data = alu_ref(bus.o_alu_op, bus.o_alu_op_a, bus.o_alu_op_b);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    bus.i_req0_op_a = '0; bus.i_req0_op_b = '0; bus.i_req0_alu_op = '0;
    bus.i_req1_op_a = '0; bus.i_req1_op_b = '0; bus.i_req1_alu_op = '0;
    bus.i_rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_alu_a"},    bus.o_alu_op_a, 0);
    chk({tag, "_alu_b"},    bus.o_alu_op_b, 0);
    chk({tag, "_alu_op"},   bus.o_alu_op, 0);
    chk({tag, "_rsp_vld"},  bus.o_rsp_valid, 0);
    chk({tag, "_rsp_id"},   bus.o_rsp_id, 0);
    chk({tag, "_rsp_dat"},  bus.o_rsp_data, 0);
    chk({tag, "_rsp_err"},  bus.o_rsp_err, 0);
  endtask

  // One transaction, entered at posedge+1 with the arbiter in IDLE.
  // hold: cycles of response backpressure; wd: port 1 raises valid for one
  // cycle while the transaction is in flight and then withdraws.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                        input int hold, input bit wd);
    bit          g;
    logic [31:0] ea, eb, ed;
    logic [3:0]  eop;
    bit          eerr;
    bus.i_req0_valid = v0; bus.i_req0_op_a = a0; bus.i_req0_op_b = b0; bus.i_req0_alu_op = op0;
    bus.i_req1_valid = v1; bus.i_req1_op_a = a1; bus.i_req1_op_b = b1; bus.i_req1_alu_op = op1;
    bus.i_rsp_ready  = 1'b0;
    #1;
    g = (v0 && v1) ? !m_last : v1;
    chk("idle_ready0", bus.o_req0_ready, v0 && !g);
    chk("idle_ready1", bus.o_req1_ready, v1 && g);
    ea   = g ? a1 : a0;
    eb   = g ? b1 : b0;
    eop  = g ? op1 : op0;
    eerr = (eop >= 4'd10);
    ed   = eerr ? 32'd0 : alu_ref(eop, ea, eb);

    @(posedge clk); #1;
    // EXEC: granted port drops valid, the loser keeps requesting
    if (g) bus.i_req1_valid = 1'b0; else bus.i_req0_valid = 1'b0;
    if (wd) begin
      bus.i_req1_valid = 1'b1; bus.i_req1_op_a = 32'h1234; bus.i_req1_op_b = 32'h1; bus.i_req1_alu_op = 4'd0;
    end
    #1;
    chk("exec_alu_a", bus.o_alu_op_a, ea);
    chk("exec_alu_b", bus.o_alu_op_b, eb);
    chk("exec_alu_op", bus.o_alu_op, eop);
    chk("exec_rsp_vld", bus.o_rsp_valid, 0);
    chk("exec_readies", {bus.o_req0_ready, bus.o_req1_ready}, 0);
    m_last = g;

    @(posedge clk); #1;
    if (wd) bus.i_req1_valid = 1'b0;
    chk("rsp_vld", bus.o_rsp_valid, 1);
    chk("rsp_id", bus.o_rsp_id, g);
    chk("rsp_dat", bus.o_rsp_data, ed);
    chk("rsp_err", bus.o_rsp_err, eerr);
    chk("rsp_readies", {bus.o_req0_ready, bus.o_req1_ready}, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", bus.o_rsp_valid, 1);
      chk("bp_id", bus.o_rsp_id, g);
      chk("bp_dat", bus.o_rsp_data, ed);
      chk("bp_err", bus.o_rsp_err, eerr);
      chk("bp_readies", {bus.o_req0_ready, bus.o_req1_ready}, 0);
      chk("bp_alu_a", bus.o_alu_op_a, ea);
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_rsp_ready  = 1'b0;
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    #1;
    chk("done_rsp_vld", bus.o_rsp_valid, 0);
    // back in IDLE: a lone request is visible immediately
    bus.i_req0_valid = 1'b1; #1;
    chk("done_idle_ready0", bus.o_req0_ready, 1);
    bus.i_req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reset asserted during EXEC (phase 1) or RESP (phase 2) of a port 1 request.
  task automatic reset_mid(input int phase);
    bus.i_req1_valid = 1'b1; bus.i_req1_op_a = 32'd9; bus.i_req1_op_b = 32'd4; bus.i_req1_alu_op = 4'd1;
    @(posedge clk); #1;
    bus.i_req1_valid = 1'b0;
    if (phase == 2) begin
      @(posedge clk); #1;
      chk("rst_pre_vld", bus.o_rsp_valid, 1);
    end
    rst_n = 1'b0; #1;
    check_reset_outputs(phase == 2 ? "rst_resp" : "rst_exec");
    chk("rst_readies", {bus.o_req0_ready, bus.o_req1_ready}, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    m_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_rsp", bus.o_rsp_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [3:0]  rop0, rop1;
    bit          rv0, rv1;
    n_cmp = 0; n_err = 0; m_last = 1'b1;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    chk("reset_readies", {bus.o_req0_ready, bus.o_req1_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request: 5 - 3 = 2
    do_txn(1, 0, 32'd5, 32'd3, 4'd1, 0, 0, 0, 0, 0);
    chk("single_last", m_last, 0);

    // Contention from a fresh reset, port 0 first
    rst_n = 1'b0; #1; rst_n = 1'b1; m_last = 1'b1;
    @(posedge clk); #1;
    do_txn(1, 1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd6, 32'd1, 32'd2, 4'd5, 0, 0);
    do_txn(1, 1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd6, 32'd1, 32'd2, 4'd5, 0, 0);
    for (int i = 0; i < 8; i++) begin
      do_txn(1, 1, $urandom, $urandom, 4'($urandom_range(0, 9)),
             $urandom, $urandom, 4'($urandom_range(0, 9)), 0, 0);
      chk("alternate", m_last, i[0]);
    end

    // Backpressure for 5 cycles with both ports requesting
    do_txn(1, 1, 32'd100, 32'd7, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd2, 5, 0);

    // Illegal opcode on port 1, then a legal request
    do_txn(0, 1, 0, 0, 0, 32'd77, 32'd66, 4'hC, 0, 0);
    do_txn(0, 1, 0, 0, 0, 32'h8000_0000, 32'd4, 4'd9, 0, 0);

    // Reset mid-operation, then contention grants port 0 first
    reset_mid(1);
    do_txn(1, 1, 32'd3, 32'd4, 4'd0, 32'd6, 32'd5, 4'd1, 0, 0);
    reset_mid(2);
    do_txn(1, 1, 32'd3, 32'd4, 4'd7, 32'd6, 32'd5, 4'd8, 0, 0);

    // Early withdrawal of port 1 during a port 0 transaction
    do_txn(1, 0, 32'd11, 32'd22, 4'd4, 0, 0, 0, 2, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("wd_no_grant", {bus.o_req0_ready, bus.o_req1_ready}, 0);
      chk("wd_alu_hold", bus.o_alu_op_a, 32'd11);
    end
    chk("wd_last", m_last, 0);
    do_txn(1, 1, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 4'd0, 0, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      rv0 = 1'($urandom); rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1'b1;
      ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
      if ($urandom_range(0, 3) == 0) rb0 = 32'($urandom_range(0, 31));
      rop0 = 4'($urandom_range(0, 15));
      rop1 = 4'($urandom_range(0, 15));
      do_txn(rv0, rv1, ra0, rb0, rop0, ra1, rb1, rop1, $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the bench is fully time-sequenced, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU datapath between two requesters: port 0 is the execute stage, port 1 is the address/branch helper.
- Arbitrates round-robin between them and uses a valid/ready request handshake.
- Registers the operands it sends to the ALU, captures the ALU result one cycle later, and holds it in a response register until the owning requester takes it.
- Sits between the requesters and the ALU instance, driving the ALU's operand and opcode inputs.

Parameters:
- XLEN, 32, operand and result width.
- OPW, 4, ALU opcode width.
- NUM_OPS, 10, count of legal opcodes (0..9: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA); codes >= NUM_OPS are illegal.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req0_valid / i_req1_valid  in  1  request present on port 0 / 1.
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle.
- i_req0_op_a, i_req0_op_b, i_req1_op_a, i_req1_op_b  in  XLEN  operands.
- i_req0_alu_op / i_req1_alu_op  in  OPW  opcode.
- o_alu_op_a, o_alu_op_b  out  XLEN  registered operands driven to the ALU.
- o_alu_op  out  OPW  registered opcode driven to the ALU.
- i_alu_data  in  XLEN  combinational ALU result.
- o_rsp_valid  out  1  response register holds a result.
- o_rsp_id  out  1  requester that owns the response (0/1).
- o_rsp_data  out  XLEN  result.
- o_rsp_err  out  1  request carried an illegal opcode.
- i_rsp_ready  in  1  the owning requester consumes the response.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; last_grant=1, so port 0 wins the first contention.
  - o_alu_op_a=0, o_alu_op_b=0, o_alu_op=0 (ADD).
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_rsp_err=0.
- IDLE:
  - Ready is combinational and only asserted here. If only one port is valid, that port's ready=1.
  - If both are valid, ready goes to the port != last_grant; the other port's ready=0.
  - On a grant edge: latch the granted operands and opcode into the o_alu_* registers, latch the granted id, set last_grant=id, go to EXEC.
  - No valid requests: stay in IDLE and hold the o_alu_* registers.
- EXEC (exactly one cycle):
  - Both readies are 0.
  - At the edge: o_rsp_data = i_alu_data, o_rsp_valid=1, o_rsp_id = the latched id.
  - If the latched opcode >= NUM_OPS: o_rsp_data=0 and o_rsp_err=1. Otherwise o_rsp_err=0.
  - Go to RESP.
- RESP:
  - Both readies are 0; the response outputs are held stable.
  - On i_rsp_ready=1 at an edge: o_rsp_valid=0, go to IDLE.
  - Because IDLE is entered on that edge, there is no back-to-back grant in the same cycle.
- Latency and throughput:
  - Grant at edge N; o_rsp_valid is high after edge N+1.
  - Minimum 3 cycles per transaction (IDLE, EXEC, RESP with immediate ready).
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.
- Starvation-free: with both ports continuously valid, grants strictly alternate 0,1,0,1.
- A requester dropping valid before grant simply forfeits; last_grant is unchanged.
- Reset asserted in EXEC or RESP: the pending transaction is discarded, no response is produced, and all outputs return to their reset values immediately.
- The o_alu_* registers change only on grant edges.

Test Plan:
- Single request: req0 op_a=5, op_b=3, op=SUB, rsp_ready tied 1 -> ready0=1 for one cycle; o_rsp_valid=1 two edges later with data=2, id=0, err=0; arbiter back in IDLE the next cycle.
- Contention after reset: both valid, req0 AND 0xF0F0F0F0 & 0xFF00FF00, req1 OR 1|2 -> port 0 granted first with data=0xF000F000, id=0; port 1 granted next with data=3, id=1; then alternation 0,1,0,1 over 8 back-to-back transactions.
- Response backpressure: i_rsp_ready=0 for 5 cycles after o_rsp_valid -> data, id and err stable, both readies 0, no new grant; grant resumes in the cycle after ready.
- Illegal opcode: req1 op=4'hC -> o_rsp_err=1, o_rsp_data=0, id=1; a following legal request gives err=0.
- Reset mid-operation: assert i_rst_n=0 during EXEC, then during RESP -> outputs go to 0 asynchronously, no response after release, and a simultaneous request pair grants port 0 first.
- Early withdrawal: req1 valid for one cycle while a port 0 transaction is in progress, then dropped -> no grant to port 1 and last_grant stays 0.
